inbuf_packet_scheduler: RTL and testbench

Hardware sequencer that shares the input-buffer packet path (token-id write plus byte-serial word stream into the word-to-bit converter) among `NUM_REQ` packet sources. It replaces the software loop of separate token-id and word-data register writes. It sits between the NoC/router receive ports and the input-buffer port, upstream of `word2bit_trans_unit` and the token table. Sources are arbitrated round-robin, one whole packet at a time. The token id is issued first, then the granted source's words stream out, and the grant is held until the converter reports `trans_done`.

---
 rtl/inbuf_packet_scheduler_pkg.sv | 30 +++
 rtl/inbuf_packet_scheduler_if.sv | 48 ++++
 rtl/inbuf_packet_scheduler_rr_arbiter.sv | 36 +++
 rtl/inbuf_packet_scheduler.sv | 104 ++++++++++
 tb/tb_inbuf_packet_scheduler.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inbuf_packet_scheduler_pkg.sv
// inbuf_pkg: state encoding, FSM state type and width helpers for the input-buffer packet scheduler.
// Rev 1.0
`default_nettype none

package inbuf_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_HDR  = S_HDR,
    ST_DATA = S_DATA,
    ST_WAIT = S_WAIT
  } state_t;

  function automatic int tidw(input int entries);
    return $clog2(entries);
  endfunction

  // Bits needed to hold a word count of 0..max_words.
  function automatic int lenw(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inbuf_packet_scheduler_if.sv
// inbuf_packet_scheduler_if: source headers/words, converter handshake and status of the scheduler.
// Rev 1.0
`default_nettype none

interface inbuf_packet_scheduler_if #(
  parameter int NUM_REQ           = 4,
  parameter int TOKEN_TABLE_ENTRY = 32,
  parameter int LEN_W             = 8
);
  import inbuf_pkg::*;

  localparam int TIDW = tidw(TOKEN_TABLE_ENTRY);

  logic [NUM_REQ-1:0]       req_vld_i;
  logic [NUM_REQ*TIDW-1:0]  req_token_id_i;
  logic [NUM_REQ*LEN_W-1:0] req_len_i;
  logic [NUM_REQ-1:0]       req_rdy_o;
  logic [NUM_REQ*8-1:0]     word_data_i;
  logic [NUM_REQ-1:0]       word_vld_i;
  logic [NUM_REQ-1:0]       word_rdy_o;
  logic [TIDW-1:0]          token_id_o;
  logic                     token_id_vld_o;
  logic [7:0]               word_data_o;
  logic                     word_vld_o;
  logic                     word_rdy_i;
  logic                     trans_done_i;
  logic [NUM_REQ-1:0]       grant_o;
  logic                     busy_o;
  logic                     err_o;
  logic [15:0]              pkt_cnt_o;

  modport master (
    input  req_vld_i, req_token_id_i, req_len_i, word_data_i, word_vld_i,
           word_rdy_i, trans_done_i,
    output req_rdy_o, word_rdy_o, token_id_o, token_id_vld_o, word_data_o,
           word_vld_o, grant_o, busy_o, err_o, pkt_cnt_o
  );

  modport slave (
    output req_vld_i, req_token_id_i, req_len_i, word_data_i, word_vld_i,
           word_rdy_i, trans_done_i,
    input  req_rdy_o, word_rdy_o, token_id_o, token_id_vld_o, word_data_o,
           word_vld_o, grant_o, busy_o, err_o, pkt_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/inbuf_packet_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority arbiter; the search starts just after `last`.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int k;

  // Walk from the farthest candidate back to the nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    k   = 0;
    for (int i = N; i >= 1; i--) begin
      k = int'(last) + i;
      if (k >= N) k = k - N;
      if (req[IW'(k)]) begin
        gnt          = '0;
        gnt[IW'(k)]  = 1'b1;
        idx          = IW'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/inbuf_packet_scheduler.sv
// inbuf_packet_scheduler: round-robin sequencer issuing token id then byte stream, one packet per grant.
// Rev 1.0
`default_nettype none

module inbuf_packet_scheduler
  import inbuf_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int TOKEN_TABLE_ENTRY = 32,
  parameter int LEN_W             = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  inbuf_packet_scheduler_if.master  bus
);

  localparam int TIDW = tidw(TOKEN_TABLE_ENTRY);
  localparam int IW   = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IW-1:0]      win_idx;
  logic [TIDW-1:0]    token_id;
  logic [LEN_W-1:0]   remain;
  logic [7:0]         word_data;
  logic               word_vld;
  logic               err;
  logic [15:0]        pkt_cnt;
  logic               accept, xfer, done;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req  (bus.req_vld_i),
    .last (last_grant),
    .gnt  (win_gnt),
    .idx  (win_idx)
  );

  assign accept = (state == ST_IDLE) && (|win_gnt);
  assign xfer   = (state == ST_DATA) && bus.word_vld_i[grant_idx] && bus.word_rdy_i;
  assign done   = (state == ST_WAIT) && bus.trans_done_i;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_HDR;
      ST_HDR:  state_nxt = (remain == '0) ? ST_WAIT : ST_DATA;
      ST_DATA: if (xfer && (remain == LEN_W'(1))) state_nxt = ST_WAIT;
      ST_WAIT: if (bus.trans_done_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_idx  <= '0;
      grant      <= '0;
      token_id   <= '0;
      remain     <= '0;
      word_data  <= '0;
      word_vld   <= 1'b0;
      err        <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      word_vld <= xfer;
      if (accept) begin
        grant     <= win_gnt;
        grant_idx <= win_idx;
        token_id  <= bus.req_token_id_i[win_idx*TIDW +: TIDW];
        remain    <= bus.req_len_i[win_idx*LEN_W +: LEN_W];
      end
      if (xfer) begin
        word_data <= bus.word_data_i[grant_idx*8 +: 8];
        remain    <= remain - LEN_W'(1);
      end
      if (done) begin
        last_grant <= grant_idx;
        pkt_cnt    <= pkt_cnt + 16'd1;
        grant      <= '0;
      end
      // A completion outside WAIT never advances the FSM; it only flags the protocol error.
      if (bus.trans_done_i && (state != ST_WAIT)) err <= 1'b1;
    end
  end

  assign bus.req_rdy_o      = (state == ST_IDLE) ? win_gnt : '0;
  assign bus.word_rdy_o     = ((state == ST_DATA) && bus.word_rdy_i) ? grant : '0;
  assign bus.token_id_o     = token_id;
  assign bus.token_id_vld_o = (state == ST_HDR);
  assign bus.word_data_o    = word_data;
  assign bus.word_vld_o     = word_vld;
  assign bus.grant_o        = grant;
  assign bus.busy_o         = (state != ST_IDLE);
  assign bus.err_o          = err;
  assign bus.pkt_cnt_o      = pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inbuf_packet_scheduler.sv
// tb_inbuf_packet_scheduler: scoreboard bench; headers and bytes are queued as packets are offered.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_inbuf_packet_scheduler;
  import inbuf_pkg::*;

  localparam int NR  = 4;
  localparam int TTE = 32;
  localparam int LW  = 8;
  localparam int TW  = $clog2(TTE);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inbuf_packet_scheduler_if #(.NUM_REQ(NR), .TOKEN_TABLE_ENTRY(TTE), .LEN_W(LW)) bus ();

  inbuf_packet_scheduler #(.NUM_REQ(NR), .TOKEN_TABLE_ENTRY(TTE), .LEN_W(LW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int src;
    int id;
    int len;
  } hdr_t;

  hdr_t exp_hdr[$];
  int   exp_wd[$];
  int   pq_id[NR][$];
  int   pq_len[NR][$];
  int   wq[NR][$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_left = 0;
  int   done_pend = 0;
  int   done_wait = 0;
  int   done_dly = 0;
  int   hdr_seen = 0;
  int   wd_seen = 0;
  bit   toggle_rdy = 1'b0;
  logic prev_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (pq_id[k].size() > 0) begin
        bus.req_vld_i[k]              = 1'b1;
        bus.req_token_id_i[k*TW +: TW] = TW'(pq_id[k][0]);
        bus.req_len_i[k*LW +: LW]      = LW'(pq_len[k][0]);
      end else begin
        bus.req_vld_i[k]              = 1'b0;
        bus.req_token_id_i[k*TW +: TW] = '0;
        bus.req_len_i[k*LW +: LW]      = '0;
      end
      if (wq[k].size() > 0) begin
        bus.word_vld_i[k]         = 1'b1;
        bus.word_data_i[k*8 +: 8] = 8'(wq[k][0]);
      end else begin
        bus.word_vld_i[k]         = 1'b0;
        bus.word_data_i[k*8 +: 8] = 8'h00;
      end
    end
  endtask

  // Offer a packet; `avail` of its bytes are actually made available by the source.
  task automatic add_pkt(input int src, input int id, input int len, input int avail);
    hdr_t h;
    h.src = src; h.id = id; h.len = len;
    exp_hdr.push_back(h);
    pq_id[src].push_back(id);
    pq_len[src].push_back(len);
    for (int i = 0; i < len; i++) begin
      exp_wd.push_back((id * 16 + i) & 255);
      if (i < avail) wq[src].push_back((id * 16 + i) & 255);
    end
    drive();
  endtask

  task automatic step();
    hdr_t h;
    logic [NR-1:0] hf, wf;
    @(negedge clk);
    if (bus.token_id_vld_o) begin
      hdr_seen++;
      if (exp_hdr.size() == 0) chk("hdr_unexpected", 32'(bus.token_id_vld_o), 0);
      else begin
        h = exp_hdr.pop_front();
        chk("hdr_id", 32'(bus.token_id_o), h.id);
        chk("hdr_grant", 32'(bus.grant_o), 1 << h.src);
        cur_left = h.len;
        if (h.len == 0) begin done_pend = 1; done_wait = done_dly + 1; end
      end
    end
    if (bus.word_vld_o) begin
      wd_seen++;
      chk("word_after_rdy", 32'(prev_rdy), 1);
      if (exp_wd.size() == 0) chk("word_unexpected", 32'(bus.word_vld_o), 0);
      else chk("word_data", 32'(bus.word_data_o), exp_wd.pop_front());
      cur_left--;
      if (cur_left == 0) begin done_pend = 1; done_wait = done_dly; end
    end
    if (done_pend != 0) begin
      if (done_wait == 0) begin bus.trans_done_i = 1'b1; done_pend = 0; end
      else done_wait--;
    end
    prev_rdy = bus.word_rdy_i;
    hf = bus.req_rdy_o & bus.req_vld_i;
    wf = bus.word_rdy_o & bus.word_vld_i;
    @(posedge clk); #1;
    bus.trans_done_i = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (hf[k]) begin
        void'(pq_id[k].pop_front());
        void'(pq_len[k].pop_front());
      end
      if (wf[k]) void'(wq[k].pop_front());
    end
    if (toggle_rdy) bus.word_rdy_i = ~bus.word_rdy_i;
    drive();
  endtask

  task automatic run_done(input int max_cyc);
    int n;
    n = 0;
    while ((exp_hdr.size() > 0 || exp_wd.size() > 0 || bus.busy_o || done_pend != 0) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) chk("timeout_run_done", 32'(bus.busy_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws, hs, n;
    bus.req_vld_i      = '0;
    bus.req_token_id_i = '0;
    bus.req_len_i      = '0;
    bus.word_data_i    = '0;
    bus.word_vld_i     = '0;
    bus.word_rdy_i     = 1'b0;
    bus.trans_done_i   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_pkt_cnt", 32'(bus.pkt_cnt_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_tid_vld", 32'(bus.token_id_vld_o), 0);
    chk("rst_word_vld", 32'(bus.word_vld_o), 0);
    chk("rst_req_rdy", 32'(bus.req_rdy_o), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single source 0, id 5, three bytes, completion two cycles after the last byte.
    bus.word_rdy_i = 1'b1;
    done_dly = 2;
    add_pkt(0, 5, 3, 3);
    run_done(100);
    chk("t1_pkt_cnt", 32'(bus.pkt_cnt_o), 1);
    chk("t1_grant_idle", 32'(bus.grant_o), 0);

    // Header-only packet from source 3.
    done_dly = 1;
    ws = wd_seen;
    add_pkt(3, 9, 0, 0);
    run_done(100);
    chk("h0_no_words", 32'(wd_seen - ws), 0);
    chk("h0_pkt_cnt", 32'(bus.pkt_cnt_o), 2);

    // All four sources busy: expect 0,1,2,3,0,1,2,3; completion in the first WAIT cycle.
    done_dly = 0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NR; s++)
        add_pkt(s, 16 + p * 4 + s, 1, 1);
    run_done(400);
    chk("rr_pkt_cnt", 32'(bus.pkt_cnt_o), 10);

    // Converter ready toggling every cycle, four bytes.
    done_dly = 1;
    toggle_rdy = 1'b1;
    ws = wd_seen;
    add_pkt(1, 7, 4, 4);
    run_done(200);
    toggle_rdy = 1'b0;
    bus.word_rdy_i = 1'b1;
    chk("tog_words", 32'(wd_seen - ws), 4);
    chk("tog_pkt_cnt", 32'(bus.pkt_cnt_o), 11);

    // Stray completion while in DATA.
    bus.word_rdy_i = 1'b0;
    hs = hdr_seen;
    add_pkt(2, 11, 2, 2);
    n = 0;
    while (hdr_seen == hs && n < 20) begin step(); n++; end
    if (n >= 20) chk("timeout_err_hdr", 32'(hdr_seen - hs), 1);
    bus.trans_done_i = 1'b1;
    step();
    chk("err_set", 32'(bus.err_o), 1);
    chk("err_still_busy", 32'(bus.busy_o), 1);
    chk("err_pkt_hold", 32'(bus.pkt_cnt_o), 11);
    bus.word_rdy_i = 1'b1;
    run_done(100);
    chk("err_sticky", 32'(bus.err_o), 1);
    chk("err_pkt_cnt", 32'(bus.pkt_cnt_o), 12);

    // Reset in the middle of DATA after two of five bytes.
    done_dly = 0;
    ws = wd_seen;
    add_pkt(0, 3, 5, 2);
    n = 0;
    while ((wd_seen - ws) < 2 && n < 30) begin step(); n++; end
    if (n >= 30) chk("timeout_mid_data", 32'(wd_seen - ws), 2);
    chk("mid_busy", 32'(bus.busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.grant_o), 0);
    chk("arst_busy", 32'(bus.busy_o), 0);
    chk("arst_pkt_cnt", 32'(bus.pkt_cnt_o), 0);
    chk("arst_err", 32'(bus.err_o), 0);
    chk("arst_word_vld", 32'(bus.word_vld_o), 0);
    chk("arst_word_rdy", 32'(bus.word_rdy_o), 0);
    chk("arst_tid_vld", 32'(bus.token_id_vld_o), 0);
    exp_hdr.delete();
    exp_wd.delete();
    for (int k = 0; k < NR; k++) begin
      pq_id[k].delete();
      pq_len[k].delete();
      wq[k].delete();
    end
    cur_left = 0;
    done_pend = 0;
    drive();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    add_pkt(0, 1, 1, 1);
    add_pkt(3, 2, 1, 1);
    run_done(100);
    chk("post_rst_pkt_cnt", 32'(bus.pkt_cnt_o), 2);
    chk("post_rst_err", 32'(bus.err_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
